// File: rtl/pipe_step_ctrl.sv
// Step sequencer for the board-level pipelined MIPS datapath: issues pipeline
// clock pulses (single-step or free-run), requests LCD refreshes and stops on PC breakpoints.
module pipe_step_ctrl #(
    parameter int PULSE_W  = 4,
    parameter int SETTLE_W = 4,
    parameter int RUN_DIV  = 25000000,
    parameter int DIV_W    = 25
) (
    input  logic        i_cclk,
    input  logic        i_rst_n,
    input  logic        i_step_btn,
    input  logic        i_run_sw,
    input  logic        i_bp_en,
    input  logic [31:0] i_bp_pc,
    input  logic [31:0] i_pc,
    input  logic        i_lcd_busy,
    output logic        o_pipe_clk,
    output logic [7:0]  o_clk_cnt,
    output logic        o_lcd_refresh,
    output logic        o_halted,
    output logic [2:0]  o_state
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_PULSE    = 3'd1,
        S_SETTLE   = 3'd2,
        S_REFRESH  = 3'd3,
        S_WAIT_LCD = 3'd4,
        S_GAP      = 3'd5,
        S_HALT     = 3'd6
    } state_t;

    localparam logic [DIV_W-1:0] LP_PULSE_LAST  = DIV_W'(PULSE_W - 1);
    localparam logic [DIV_W-1:0] LP_SETTLE_LAST = DIV_W'(SETTLE_W - 1);
    localparam logic [DIV_W-1:0] LP_GAP_LAST    = DIV_W'(RUN_DIV - 1);

    state_t           r_state;
    state_t           w_next;
    logic [DIV_W-1:0] r_cnt;
    logic [7:0]       r_clk_cnt;
    logic             r_btn_q;
    logic             r_btn_prev;
    logic             r_pipe_clk;
    logic             r_lcd_refresh;
    logic             r_halted;
    logic             w_step_edge;
    logic             w_bp_hit;
    logic             w_counting;
    logic             w_pipe_clk_d;
    logic             w_lcd_refresh_d;
    logic             w_halted_d;

    assign w_step_edge = r_btn_q & ~r_btn_prev;
    assign w_bp_hit    = i_bp_en && (i_pc == i_bp_pc);
    assign w_counting  = (r_state == S_PULSE) || (r_state == S_SETTLE) || (r_state == S_GAP);

    // Display handshake: o_lcd_refresh is a one-cycle strobe; the display raises
    // i_lcd_busy while it redraws, and no further step is issued until i_lcd_busy is
    // low, sampled from the cycle after the strobe onwards.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:     if (w_step_edge || i_run_sw) w_next = S_PULSE;
            S_PULSE:    if (r_cnt == LP_PULSE_LAST) w_next = S_SETTLE;
            S_SETTLE:   if (r_cnt == LP_SETTLE_LAST) w_next = S_REFRESH;
            S_REFRESH:  w_next = S_WAIT_LCD;
            S_WAIT_LCD: begin
                if (!i_lcd_busy) begin
                    if (w_bp_hit)      w_next = S_HALT;
                    else if (i_run_sw) w_next = S_GAP;
                    else               w_next = S_IDLE;
                end
            end
            S_GAP: begin
                if (!i_run_sw)                 w_next = S_IDLE;
                else if (r_cnt == LP_GAP_LAST) w_next = S_PULSE;
            end
            S_HALT: begin
                if (w_step_edge)   w_next = S_PULSE;
                else if (!i_bp_en) w_next = S_IDLE;
            end
            default:    w_next = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state and then registered, so they line up with r_state.
    always_comb begin
        w_pipe_clk_d    = (w_next == S_PULSE);
        w_lcd_refresh_d = (w_next == S_REFRESH);
        w_halted_d      = (w_next == S_HALT);
    end

    always_ff @(posedge i_cclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            r_clk_cnt     <= 8'd0;
            r_btn_q       <= 1'b0;
            r_btn_prev    <= 1'b0;
            r_pipe_clk    <= 1'b0;
            r_lcd_refresh <= 1'b0;
            r_halted      <= 1'b0;
        end else begin
            r_state       <= w_next;
            r_btn_q       <= i_step_btn;
            r_btn_prev    <= r_btn_q;
            r_pipe_clk    <= w_pipe_clk_d;
            r_lcd_refresh <= w_lcd_refresh_d;
            r_halted      <= w_halted_d;
            if (w_next != r_state) r_cnt <= '0;
            else if (w_counting)   r_cnt <= r_cnt + 1'b1;
            if ((w_next == S_PULSE) && (r_state != S_PULSE)) r_clk_cnt <= r_clk_cnt + 8'd1;
        end
    end

    assign o_pipe_clk    = r_pipe_clk;
    assign o_clk_cnt     = r_clk_cnt;
    assign o_lcd_refresh = r_lcd_refresh;
    assign o_halted      = r_halted;
    assign o_state       = r_state;

endmodule
